// File: rtl/mpu_matrix_loader_if.sv
// rtl/mpu_matrix_loader_if.sv - stream-in / matrix-out bundle for the MPU operand loader
//
// Purpose: groups the element stream handshake and the parallel matrix
// outputs that connect the loader to its source and to the adder stage.
// Ports (signals):
//   in_data, in_valid    element stream from the source
//   in_ready             loader can accept an element this cycle
//   matrix_a, matrix_b   flattened SIZE x SIZE matrices, element (i,j) at [(i*SIZE+j)*WIDTH +: WIDTH]
//   matrices_valid       both matrices complete and stable
//   consume              adder side has taken the current pair
//   load_index           elements accepted in the current pair
// Modports: master = source/adder side, slave = loader.

interface mpu_matrix_loader_if #(
  parameter int SIZE  = 5,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [SIZE*SIZE*WIDTH-1:0] matrix_a;
  logic [SIZE*SIZE*WIDTH-1:0] matrix_b;
  logic                       matrices_valid;
  logic                       consume;
  logic [5:0]                 load_index;

  modport master (
    output in_data, in_valid, consume,
    input  in_ready, matrix_a, matrix_b, matrices_valid, load_index
  );

  modport slave (
    input  in_data, in_valid, consume,
    output in_ready, matrix_a, matrix_b, matrices_valid, load_index
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// rtl/mpu_matrix_loader.sv - assembles two SIZE x SIZE matrices from a byte stream for the MPU adder
//
// Purpose: accepts elements over a valid/ready handshake, fills matrix A then
// matrix B in row-major order, presents both with matrices_valid until the
// adder side pulses consume, then rearms for the next pair.
// Ports:
//   clock   single clock, rising edge
//   reset   synchronous, active-high
//   abort   (only with MPU_LOADER_ABORT_EN defined) drop the partial pair and return to LOAD_A
//   bus     mpu_matrix_loader_if.slave (stream in, matrices out, consume, load_index)
// Optional feature macro: MPU_LOADER_ABORT_EN.

module mpu_matrix_loader #(
  parameter int SIZE  = 5,
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
`ifdef MPU_LOADER_ABORT_EN
  input  logic abort,
`endif
  mpu_matrix_loader_if.slave bus
);

  localparam int N  = SIZE * SIZE;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [5:0]         idx_q, idx_d;
  logic [N*WIDTH-1:0] mat_a_q, mat_a_d;
  logic [N*WIDTH-1:0] mat_b_q, mat_b_d;

  logic abort_i;
  logic take;
  int   elem;

`ifdef MPU_LOADER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Ready depends only on registered state, so the source can stream one
  // element per cycle with no bubble between A and B.
  assign bus.in_ready = (state_q != FULL) && !reset;

  // An abort in the same cycle as a handshake drops that element.
  assign take = bus.in_valid && bus.in_ready && !abort_i;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    elem    = int'(row_q) * SIZE + int'(col_q);

    if (take) begin
      for (int e = 0; e < N; e++) begin
        if (e == elem) begin
          if (state_q == LOAD_A) begin
            mat_a_d[e*WIDTH +: WIDTH] = bus.in_data;
          end else begin
            mat_b_d[e*WIDTH +: WIDTH] = bus.in_data;
          end
        end
      end
      idx_d = idx_q + 6'd1;
      if (col_q == CW'(SIZE - 1)) begin
        col_d = '0;
        if (row_q == CW'(SIZE - 1)) begin
          row_d   = '0;
          state_d = (state_q == LOAD_A) ? LOAD_B : FULL;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // Rearm keeps matrix contents; they are simply overwritten by the next pair.
    if ((state_q == FULL && bus.consume) || abort_i) begin
      state_d = LOAD_A;
      row_d   = '0;
      col_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD_A;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  end

  assign bus.matrix_a       = mat_a_q;
  assign bus.matrix_b       = mat_b_q;
  assign bus.matrices_valid = (state_q == FULL);
  assign bus.load_index     = idx_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// tb/tb_mpu_matrix_loader.sv - directed self-checking bench for mpu_matrix_loader

module tb_mpu_matrix_loader;
  localparam int SIZE  = 5;
  localparam int WIDTH = 8;
  localparam int N     = SIZE * SIZE;

  logic clock = 1'b0;
  logic reset;
`ifdef MPU_LOADER_ABORT_EN
  logic abort;
`endif

  mpu_matrix_loader_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

  mpu_matrix_loader #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
`ifdef MPU_LOADER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int idx_model;
  logic [7:0] exp_a [N];
  logic [7:0] exp_b [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] a_el(input int e);
    return bus.matrix_a[e*WIDTH +: WIDTH];
  endfunction

  function automatic logic [7:0] b_el(input int e);
    return bus.matrix_b[e*WIDTH +: WIDTH];
  endfunction

  function automatic logic [7:0] val(input int seed, input int k);
    int v;
    case (seed)
      0:       v = (k < 25) ? k + 1 : k + 76;
      1:       v = k * 7 + 3;
      2:       v = 255 - k;
      default: v = k ^ 8'h5A;
    endcase
    return v[7:0];
  endfunction

  task automatic check_mats(input string tag);
    for (int e = 0; e < N; e++) begin
      check({tag, "_a"}, a_el(e), exp_a[e]);
      check({tag, "_b"}, b_el(e), exp_b[e]);
    end
  endtask

  // One transfer per cycle from the current pair position.
  task automatic stream(input int n, input int seed);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = val(seed, idx_model);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (idx_model < N) exp_a[idx_model] = d;
      else               exp_b[idx_model - N] = d;
      check("stream_rdy", bus.in_ready, 1);
      tick();
      idx_model++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_consume();
    bus.consume = 1'b1;
    tick();
    bus.consume = 1'b0;
    idx_model   = 0;
  endtask

  initial begin
    int not_ready;
    logic [7:0] d;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.consume  = 1'b0;
`ifdef MPU_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    for (int e = 0; e < N; e++) begin
      exp_a[e] = '0;
      exp_b[e] = '0;
    end
    idx_model = 0;

    // Reset state
    tick();
    tick();
    check("rst_ready", bus.in_ready, 0);
    check("rst_valid", bus.matrices_valid, 0);
    check("rst_index", bus.load_index, 0);
    check("rst_mat_a", |bus.matrix_a, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", bus.in_ready, 1);

    // Back-to-back pair 1..25 / 101..125
    stream(50, 0);
    check("full_valid", bus.matrices_valid, 1);
    check("full_index", bus.load_index, 50);
    check("a00", a_el(0), 8'd1);
    check("a44", a_el(24), 8'd25);
    check("b23", b_el(13), 8'd114);

    // Held in FULL with in_valid asserted
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      check("hold_ready", bus.in_ready, 0);
      tick();
      check("hold_valid", bus.matrices_valid, 1);
    end
    bus.in_valid = 1'b0;
    check("hold_index", bus.load_index, 50);
    check_mats("hold");
    do_consume();
    check("cons_valid", bus.matrices_valid, 0);
    check("cons_ready", bus.in_ready, 1);
    check("cons_index", bus.load_index, 0);
    check("cons_retain", a_el(0), 8'd1);

    // in_valid every other cycle
    not_ready = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 2 == 0) begin
        d = val(1, c / 2);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (c / 2 < N) exp_a[c / 2] = d;
        else           exp_b[c / 2 - N] = d;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (c < 99 && !bus.in_ready) not_ready++;
      tick();
    end
    check("tog_not_ready", not_ready, 0);
    check("tog_valid", bus.matrices_valid, 1);
    check("tog_ready", bus.in_ready, 0);
    check("tog_index", bus.load_index, 50);
    check("tog_a10", a_el(5), val(1, 5));
    check_mats("tog");
    do_consume();

    // Reset after 30 transfers, then a fresh load
    stream(30, 3);
    check("mid_index", bus.load_index, 30);
    reset = 1'b1;
    tick();
    check("mreset_index", bus.load_index, 0);
    check("mreset_valid", bus.matrices_valid, 0);
    check("mreset_a", |bus.matrix_a, 0);
    check("mreset_b", |bus.matrix_b, 0);
    reset = 1'b0;
    #1;
    check("mreset_ready", bus.in_ready, 1);
    for (int e = 0; e < N; e++) begin
      exp_a[e] = '0;
      exp_b[e] = '0;
    end
    idx_model = 0;
    stream(50, 2);
    check("fresh_valid", bus.matrices_valid, 1);
    check("fresh_index", bus.load_index, 50);
    check_mats("fresh");

    // consume and in_valid in the same FULL cycle
    bus.consume  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    check("cv_ready_full", bus.in_ready, 0);
    tick();
    bus.consume = 1'b0;
    check("cv_ready", bus.in_ready, 1);
    check("cv_valid", bus.matrices_valid, 0);
    check("cv_index0", bus.load_index, 0);
    check("cv_a00_old", a_el(0), 8'd255);
    tick();
    bus.in_valid = 1'b0;
    check("cv_index1", bus.load_index, 1);
    check("cv_a00", a_el(0), 8'hAA);
    check("cv_a01", a_el(1), 8'd254);
    exp_a[0]  = 8'hAA;
    idx_model = 1;

`ifdef MPU_LOADER_ABORT_EN
    // Abort on the 12th transfer drops that element
    stream(10, 3);
    check("ab_pre_index", bus.load_index, 11);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check("ab_index", bus.load_index, 0);
    check("ab_valid", bus.matrices_valid, 0);
    check("ab_a21", a_el(11), exp_a[11]);
    idx_model = 0;
    stream(50, 1);
    check("ab_full_valid", bus.matrices_valid, 1);
    abort       = 1'b1;
    bus.consume = 1'b1;
    tick();
    abort       = 1'b0;
    bus.consume = 1'b0;
    check("ab_full_valid0", bus.matrices_valid, 0);
    check("ab_full_ready", bus.in_ready, 1);
    check("ab_full_index", bus.load_index, 0);
    check_mats("ab_retain");
    idx_model = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
